sram_march_bist: RTL

- Parametrised built-in self-test controller for the on-chip SRAM test macro.
- Runs a March C- sequence over the full address space through a synchronous single-port SRAM interface and compares read data against the expected background.
- Reports pass/fail, the first failing address and element, and a saturating error count.
- Sits between the TinyTapeout pin wrapper (start/status on ui/uo pins) and the SRAM macro; replaces the fixed, hand-driven test top.

---
 rtl/sram_march_bist.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sram_march_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_march_bist                                              |
// | Description : March C- built-in self-test controller for a synchronous     |
// |               single-port SRAM. Reports pass/fail, first failing address   |
// |               and element, and a saturating mismatch count.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_march_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE      = 3'd1,
    S_READ_ISSUE = 3'd2,
    S_READ_WAIT  = 3'd3,
    S_COMPARE    = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] C_ADDR_MAX  = '1;
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;
  localparam logic [2:0]        C_LAST_ELEM = 3'd5;
  // READ_WAIT lasts RD_LAT-1 cycles; the counter runs down to zero.
  localparam logic [1:0]        C_WAIT_INIT = 2'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

  state_t              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          wait_q, wait_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   fail_addr_q;
  logic [2:0]          fail_elem_q;
  logic                seen_q;
  logic                pass_q, busy_q, done_q;
  logic                en_q, we_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                w_down, w_down_nxt, w_last, w_step;
  logic                w_start, w_mismatch;
  logic [2:0]          w_elem_nxt;
  logic [DATA_W-1:0]   w_exp;

  // Element decode: M3/M4 walk downwards, M2/M4 expect the all-ones background.
  assign w_down     = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign w_elem_nxt = elem_q + 3'd1;
  assign w_down_nxt = (w_elem_nxt == 3'd3) || (w_elem_nxt == 3'd4);
  assign w_last     = w_down ? (addr_q == '0) : (addr_q == C_ADDR_MAX);
  assign w_exp      = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
  assign w_start    = (state_q == S_IDLE) && start && !abort;
  assign w_mismatch = (state_q == S_COMPARE) && !abort && (sram_rdata != w_exp);

  // Next-state, address and element sequencing of the march.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    w_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          elem_d  = 3'd0;
          addr_d  = '0;
        end
      end
      S_WRITE: w_step = 1'b1;
      S_READ_ISSUE: begin
        if (RD_LAT == 1) begin
          state_d = S_COMPARE;
        end else begin
          state_d = S_READ_WAIT;
          wait_d  = C_WAIT_INIT;
        end
      end
      S_READ_WAIT: begin
        if (wait_q == 2'd0) state_d = S_COMPARE;
        else                wait_d  = wait_q - 2'd1;
      end
      S_COMPARE: begin
        if (elem_q == C_LAST_ELEM) w_step  = 1'b1;
        else                       state_d = S_WRITE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Last operation at this address done: move to next address or element.
    if (w_step) begin
      if (!w_last) begin
        addr_d  = w_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
        state_d = (elem_q == 3'd0) ? S_WRITE : S_READ_ISSUE;
      end else if (elem_q == C_LAST_ELEM) begin
        state_d = S_DONE;
      end else begin
        elem_d  = w_elem_nxt;
        addr_d  = w_down_nxt ? C_ADDR_MAX : '0;
        state_d = S_READ_ISSUE;
      end
    end
    if (abort) state_d = S_IDLE;
  end

  // Saturating mismatch counter, cleared when a run starts.
  always_comb begin
    err_d = err_q;
    if (w_start)                              err_d = '0;
    else if (w_mismatch && (err_q != C_CNT_MAX)) err_d = err_q + 1'b1;
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      wait_q      <= 2'd0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      seen_q      <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      en_q    <= (state_d == S_WRITE) || (state_d == S_READ_ISSUE);
      we_q    <= (state_d == S_WRITE);
      wdata_q <= ((state_d == S_WRITE) && ((elem_d == 3'd1) || (elem_d == 3'd3))) ? '1 : '0;
      if (w_start) begin
        fail_addr_q <= '0;
        fail_elem_q <= 3'd0;
        seen_q      <= 1'b0;
      end else if (w_mismatch && !seen_q) begin
        fail_addr_q <= addr_q;
        fail_elem_q <= elem_q;
        seen_q      <= 1'b1;
      end
      // pass includes a mismatch seen in the final compare cycle.
      if (w_start || (abort && busy_q)) pass_q <= 1'b0;
      else if (state_d == S_DONE)       pass_q <= (err_d == '0);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_addr  = fail_addr_q;
  assign fail_elem  = fail_elem_q;
  assign sram_en    = en_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule
`default_nettype wire
